mcu_control: RTL and testbench

MCU_CONTROL -- requirements
Module: mcu_control

---
 rtl/mcu_control.sv | 168 ++++++++++++++++
 tb/tb_mcu_control.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mcu_control.sv
// Multi-cycle MIPS-style main control FSM (Moore), with a sticky illegal-opcode flag.
// Optional addi support is compiled in with `define MCU_ADDI_EN.
module mcu_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [3:0] state,
  output logic       ill_op
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  state_e state_q, state_d;
  logic   ill_q, ill_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    ill_d   = ill_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          6'h23, 6'h2B: state_d = S_MEMADR;
          6'h00:        state_d = S_RTEXEC;
          6'h04:        state_d = S_BEQ;
          6'h02:        state_d = S_JUMP;
`ifdef MCU_ADDI_EN
          6'h08:        state_d = S_ADDIEX;
`endif
          default: begin
            state_d = S_FETCH;
            ill_d   = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (Op == 6'h23) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_RTEXEC: state_d = S_RTWB;
`ifdef MCU_ADDI_EN
      S_ADDIEX: state_d = S_ADDIWB;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // Outputs depend on state_q only; reset masks every strobe.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_RTEXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RTWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
`ifdef MCU_ADDI_EN
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: RegWrite = 1'b1;
`endif
      default: ;
    endcase
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      ALUSrcA     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      PCSource    = 2'b00;
      ALUOp       = 2'b00;
      ALUSrcB     = 2'b00;
    end
  end

  assign state  = reset ? 4'd0 : state_q;
  assign ill_op = ill_q;

endmodule

// File: tb/tb_mcu_control.sv
// Scoreboard bench for mcu_control: an instruction-level model queues
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_mcu_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic [3:0] state;
  logic       ill_op;

  mcu_control dut (
    .clk(clk), .reset(reset), .Op(Op),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcB(ALUSrcB), .state(state), .ill_op(ill_op)
  );

  always #5 clk = ~clk;

  typedef int q_t[$];
  logic [20:0] exp_q[$];
  int total = 0;
  int bad = 0;
  logic ill_m = 1'b0;
  logic prev_rw = 1'b0;

  // State sequence of one instruction, FETCH entry to FETCH re-entry.
  function automatic q_t seq_of(logic [5:0] op);
    q_t s;
    s = '{0, 1};
    case (op)
      6'h23: s = {s, 2, 3, 4};
      6'h2B: s = {s, 2, 5};
      6'h00: s = {s, 6, 7};
      6'h04: s = {s, 8};
      6'h02: s = {s, 9};
`ifdef MCU_ADDI_EN
      6'h08: s = {s, 10, 11};
`endif
      default: ;
    endcase
    return s;
  endfunction

  function automatic logic legal(logic [5:0] op);
    return seq_of(op).size() > 2;
  endfunction

  // {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
  //  IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB, ill}
  function automatic logic [20:0] pack(int st, logic ill);
    logic pcw, pcwc, iord, mr, mw, m2r, irw, sa, rw, rd;
    logic [1:0] pcs, aop, sb;
    {pcw, pcwc, iord, mr, mw, m2r, irw, sa, rw, rd} = '0;
    pcs = 2'b00; aop = 2'b00; sb = 2'b00;
    case (st)
      0:  begin mr = 1; irw = 1; pcw = 1; sb = 2'b01; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {st[3:0], pcw, pcwc, iord, mr, mw, m2r, irw, sa, rw, rd,
            pcs, aop, sb, ill};
  endfunction

  always @(negedge clk) begin
    logic [20:0] e, a;
    a = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
         IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB,
         ill_op};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle t=%0t got=%h exp=%h (state got %0d exp %0d)",
                 $time, a, e, state, e[20:17]);
      end
    end
    total++;
    if (RegWrite && (MemWrite || prev_rw)) begin
      bad++;
      $display("FAIL regwrite_rule t=%0t got RegWrite=%b MemWrite=%b prev=%b exp no overlap",
               $time, RegWrite, MemWrite, prev_rw);
    end
    prev_rw = RegWrite;
  end

  task automatic do_reset(int n);
    reset = 1'b1;
    exp_q.push_back(pack(0, ill_m) & ~21'h1ffff | {20'h0, ill_m});
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #1;
      exp_q.push_back(21'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    ill_m = 1'b0;
  endtask

  task automatic run_instr(logic [5:0] op, int abort_at);
    q_t s;
    s = seq_of(op);
    Op = op;
    for (int i = 0; i < s.size(); i++) begin
      if (i == abort_at) begin
        do_reset(2);
        return;
      end
      exp_q.push_back(pack(s[i], ill_m));
      @(posedge clk); #1;
    end
    if (!legal(op)) ill_m = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got timeout exp completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [0:6];
    logic [5:0] op;
    int wait_cnt;
    ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08, 6'h3F};
    reset = 1'b1;
    Op = 6'h00;
    @(posedge clk); #1;
    do_reset(2);
    run_instr(6'h23, -1);
    run_instr(6'h08, -1);
    run_instr(6'h3F, -1);
    run_instr(6'h02, -1);
    run_instr(6'h2B, 3);
    run_instr(6'h23, 4);
    run_instr(6'h00, -1);
    run_instr(6'h04, -1);
    run_instr(6'h11, -1);
    for (int k = 0; k < 80; k++) begin
      op = ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      if ($urandom_range(0, 9) == 0)
        run_instr(op, $urandom_range(0, 4));
      else
        run_instr(op, -1);
    end
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d exp=0 pending", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
